// File: rtl/spu_ln_pkg.sv
// Shared SPU layernorm encodings: datapath state codes and buffer sizing used by
// both the sequencer and spu_ln_block.
package spu_ln_pkg;

  typedef logic [2:0] ln_state_t;

  localparam ln_state_t LN_IDLE      = 3'b000;
  localparam ln_state_t LN_SUM_COUNT = 3'b001;
  localparam ln_state_t LN_SUM_DIV   = 3'b011;
  localparam ln_state_t LN_SQRT      = 3'b100;
  localparam ln_state_t LN_OUT       = 3'b110;

  // Row capacity in int8 elements (512 words x 4)
  localparam int OPLENGTH = 2048;

endpackage

// File: rtl/spu_ln_dly_pipe.sv
// Fixed-depth valid+address shift register matching the buffer read latency.
// A synchronous flush kills every in-flight entry.
module spu_ln_dly_pipe #(
  parameter int DEPTH  = 1,
  parameter int ADDR_W = 11
) (
  input  logic              core_clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_vld,
  output logic [ADDR_W-1:0] out_addr
);

  logic [DEPTH-1:0]  vld_p;
  logic [ADDR_W-1:0] addr_p [DEPTH];

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      for (int i = 0; i < DEPTH; i++) addr_p[i] <= '0;
    end else if (flush) begin
      vld_p <= '0;
      for (int i = 0; i < DEPTH; i++) addr_p[i] <= '0;
    end else begin
      vld_p[0]  <= in_vld;
      addr_p[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i]  <= vld_p[i-1];
        addr_p[i] <= addr_p[i-1];
      end
    end
  end

  assign out_vld  = vld_p[DEPTH-1];
  assign out_addr = addr_p[DEPTH-1];

endmodule

// File: rtl/spu_ln_ctrl.sv
// Two-pass layernorm sequencer: streams a buffer row through the accumulators,
// steps SUM_DIV and SQRT, then re-streams the row and writes normalized words back.
module spu_ln_ctrl
  import spu_ln_pkg::*;
#(
  parameter int ADDR_W       = 11,
  parameter int LEN_W        = 10,
  parameter int RD_LAT       = 1,
  parameter int SQRT_TIMEOUT = 255
) (
  input  logic              core_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [ADDR_W-1:0] cfg_rd_base,
  input  logic [ADDR_W-1:0] cfg_wr_base,
  input  logic [6:0]        cfg_div_m,
  input  logic [4:0]        cfg_div_e,
  input  logic [3:0]        cfg_shift_out,
  output logic [2:0]        ln_state,
  output logic              sum_div_cnt,
  output logic [7:0]        sqrt_cnt,
  output logic              sum_en,
  output logic [6:0]        ln_div_m,
  output logic [4:0]        ln_div_e,
  output logic [3:0]        ln_shift_output,
  input  logic              sum_div_finish,
  input  logic              sqrt_reci_finish,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Low 3 bits are the datapath code; bit 3 marks the latency drain of a pass
  localparam logic [3:0] S_IDLE      = {1'b0, LN_IDLE};
  localparam logic [3:0] S_SUM_RD    = {1'b0, LN_SUM_COUNT};
  localparam logic [3:0] S_SUM_DRAIN = {1'b1, LN_SUM_COUNT};
  localparam logic [3:0] S_SUM_DIV   = {1'b0, LN_SUM_DIV};
  localparam logic [3:0] S_SQRT      = {1'b0, LN_SQRT};
  localparam logic [3:0] S_OUT_RD    = {1'b0, LN_OUT};
  localparam logic [3:0] S_OUT_DRAIN = {1'b1, LN_OUT};

  localparam logic [LEN_W:0] IDX_ONE = {{LEN_W{1'b0}}, 1'b1};

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [3:0]        state, state_nxt;
  logic [LEN_W:0]    idx;
  logic [1:0]        dcnt;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] rd_base_q, wr_base_q;
  logic              start_ok, start_zero, rd_issue, idx_last, dcnt_last;
  logic              sqrt_tmo, sqrt_abandon, sum_pass, out_pass;
  logic              pipe_vld;
  logic [ADDR_W-1:0] pipe_addr;
  logic              sdf_unused;

  // The datapath finishes its divide in fixed time; the strobe is informational only
  assign sdf_unused = sum_div_finish;

  assign start_ok     = (state == S_IDLE) && start && !abort && (cfg_len != '0);
  assign start_zero   = (state == S_IDLE) && start && !abort && (cfg_len == '0);
  assign sum_pass     = (state[2:0] == LN_SUM_COUNT);
  assign out_pass     = (state[2:0] == LN_OUT);
  assign rd_issue     = !state[3] && (sum_pass || out_pass);
  assign idx_last     = (idx + IDX_ONE) == {1'b0, len_q};
  assign dcnt_last    = (dcnt == 2'(RD_LAT - 1));
  assign sqrt_tmo     = (sqrt_cnt >= 8'(SQRT_TIMEOUT));
  assign sqrt_abandon = (state == S_SQRT) && !abort && !sqrt_reci_finish && sqrt_tmo;

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (start_ok) state_nxt = S_SUM_RD;
        S_SUM_RD:    if (idx_last) state_nxt = S_SUM_DRAIN;
        S_SUM_DRAIN: if (dcnt_last) state_nxt = S_SUM_DIV;
        S_SUM_DIV:   if (sum_div_cnt) state_nxt = S_SQRT;
        S_SQRT: begin
          if (sqrt_reci_finish)  state_nxt = S_OUT_RD;
          else if (sqrt_tmo)     state_nxt = S_IDLE;
        end
        S_OUT_RD:    if (idx_last) state_nxt = S_OUT_DRAIN;
        S_OUT_DRAIN: if (dcnt_last) state_nxt = S_IDLE;
        default:     state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      idx             <= '0;
      dcnt            <= '0;
      sum_div_cnt     <= 1'b0;
      sqrt_cnt        <= '0;
      done            <= 1'b0;
      err             <= 1'b0;
      len_q           <= '0;
      rd_base_q       <= '0;
      wr_base_q       <= '0;
      ln_div_m        <= '0;
      ln_div_e        <= '0;
      ln_shift_output <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= (rd_issue && !idx_last && !abort) ? idx + IDX_ONE : '0;
      dcnt        <= (state[3] && !dcnt_last && !abort) ? dcnt + 2'd1 : 2'd0;
      sum_div_cnt <= (state == S_SUM_DIV) && !sum_div_cnt && !abort;
      sqrt_cnt    <= (state == S_SQRT && state_nxt == S_SQRT) ? sat_inc8(sqrt_cnt) : '0;
      done        <= ((state == S_OUT_DRAIN) && dcnt_last && !abort) || start_zero;
      if (start_ok) begin
        err             <= 1'b0;
        len_q           <= cfg_len;
        rd_base_q       <= cfg_rd_base;
        wr_base_q       <= cfg_wr_base;
        ln_div_m        <= cfg_div_m;
        ln_div_e        <= cfg_div_e;
        ln_shift_output <= cfg_shift_out;
      end else if (start_zero || sqrt_abandon) begin
        err <= 1'b1;
      end
    end
  end

  // Read issue -> data valid: the pipe carries the matching write-back address
  spu_ln_dly_pipe #(
    .DEPTH  (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_dly_pipe (
    .core_clk (core_clk),
    .rst_n    (rst_n),
    .flush    (abort),
    .in_vld   (rd_issue),
    .in_addr  (wr_base_q + ADDR_W'(idx)),
    .out_vld  (pipe_vld),
    .out_addr (pipe_addr)
  );

  assign ln_state    = state[2:0];
  assign busy        = (state != S_IDLE);
  assign buf_rd_en   = rd_issue;
  assign buf_rd_addr = rd_base_q + ADDR_W'(idx);
  assign sum_en      = pipe_vld && sum_pass;
  assign buf_wr_en   = pipe_vld && out_pass && !abort;
  assign buf_wr_addr = pipe_addr;

endmodule
